seq_alu_core: RTL
=================

# seq_alu_core

Parametrised, multi-cycle successor to the 4-bit TT ALU. It takes two WIDTH-bit operands and a 3-bit opcode through a start/busy/done handshake. Add, subtract and logic operations finish in one cycle; multiply and divide run as iterative shift-add and restoring-division engines over WIDTH cycles. It sits behind the chip-level pin wrapper, which maps operands, opcode and flags onto the ui/uo/uio pins.

## Interface
- `WIDTH`, 4: operand width in bits, ≥2; result is 2*WIDTH bits.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only when `busy`=0.
- `opcode` in 3: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 NOT (unary, uses `a`).
- `a` in WIDTH: operand A, unsigned or two's complement.
- `b` in WIDTH: operand B.
- `busy` out 1: high while MUL/DIV is iterating.
- `done` out 1: one-cycle pulse when `result`/flags update.
- `result` out 2*WIDTH: registered result, held until next `done`.
- `carry_out` out 1: ADD carry; SUB no-borrow (1 when a≥b unsigned).
- `overflow` out 1: signed overflow (ADD/SUB); MUL upper half ≠ 0.
- `zero` out 1: `result`==0.
- `div_zero` out 1: DIV with `b`==0.

## Operation
- States: IDLE, RUN.
- IDLE + `start`: latch `a`, `b`, `opcode`.
  - ADD/SUB/logic/NOT, or DIV with `b`==0: compute and write outputs at the same edge; `done`=1; stay IDLE.
  - MUL, or DIV with `b`≠0: go RUN; iteration counter=0; `busy`=1.
- RUN: one iteration per edge; counter counts 0..WIDTH-1. At the edge where counter==WIDTH-1, write outputs, pulse `done`, clear `busy`, return to IDLE.
- MUL: unsigned shift-add on latched operands; `result` = full 2*WIDTH product.
- DIV: unsigned restoring division; `result` = {remainder, quotient}, remainder in the upper WIDTH bits.
  - `b`==0: `result`=0, `div_zero`=1.
- ADD/SUB: low WIDTH bits are the sum/difference; upper WIDTH bits are 0.
  - ADD `overflow` = (a[W-1]==b[W-1]) && (s[W-1]≠a[W-1]).
  - SUB `overflow` = (a[W-1]≠b[W-1]) && (d[W-1]≠a[W-1]).
- Logic ops/NOT: zero-extended to 2*WIDTH.
- Flag clearing: every `done` rewrites all four flags; any flag not defined for the opcode is written 0.
- `zero` is always computed from the new `result`.
- `start` while `busy`=1 is ignored, with no queueing; `a`, `b` and `opcode` may change freely during RUN.
- All opcodes are defined; no illegal-opcode path.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `carry_out`=0, `overflow`=0, `zero`=0, `div_zero`=0; state IDLE.
- Single-cycle ops: `start` sampled at edge N → outputs and `done` valid after edge N (latency 1).
- MUL/DIV: `start` at edge N → `busy` high after N → `done` and outputs after edge N+WIDTH; `busy` low in that same cycle.
- Back-to-back: `start` may be asserted in the cycle `done` is high; it is accepted at the next edge. Single-cycle ops sustain 1 op/cycle.
- `done` is never high for two consecutive cycles from one request.
- `rst_n` low mid-RUN: aborts immediately and asynchronously; all outputs go to reset values; no `done` is produced.

## Configuration
- `SEQ_ALU_SAT_EN` defined: ADD/SUB saturate on signed overflow.
  - Low WIDTH bits clamp to 0111..1 on positive overflow and 1000..0 on negative overflow.
  - `overflow` still reports 1; `carry_out` is unchanged (raw).
- Not defined: ADD/SUB wrap modulo 2^WIDTH. All other opcodes are identical in both builds.

## Test plan
- Reset, then WIDTH=4, ADD a=0111 b=0001 → after 1 edge: `done`=1, `result`=0x08, `overflow`=1, `carry_out`=0. With `SEQ_ALU_SAT_EN`: `result`=0x07.
- SUB a=0011 b=0101 → `result`=0x0E, `carry_out`=0, `overflow`=0, `zero`=0; SUB a=b=0x9 → `result`=0, `zero`=1, `carry_out`=1.
- MUL a=0xF b=0xF → `busy` for 4 cycles, `done` after edge N+4, `result`=0xE1, `overflow`=1; `start` pulsed during `busy` is ignored.
- DIV a=0xD b=0x4 → after edge N+4: `result`=0x13 (rem 1, quot 3). DIV a=0x5 b=0 → after 1 edge: `result`=0, `div_zero`=1.
- Logic back-to-back with `start` held high: AND 0xC&0xA → 0x08, OR → 0x0E, XOR → 0x06, NOT a=0xC → 0x03. One `done` per cycle, each result a cycle apart.
- Assert `rst_n` low at RUN cycle 2 of a MUL → outputs zero immediately, no `done`; after release, a fresh MUL 3×5 → 0x0F.

Source files
------------

// File: rtl/seq_alu_core.sv
// Multi-cycle ALU: 1-cycle add/sub/logic, WIDTH-cycle shift-add MUL and restoring DIV.
// Define SEQ_ALU_SAT_EN to saturate ADD/SUB on signed overflow.
module seq_alu_core #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [2:0]         opcode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               carry_out,
   output logic               overflow,
   output logic               zero,
   output logic               div_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b010,
      OP_DIV = 3'b011,
      OP_AND = 3'b100,
      OP_OR  = 3'b101,
      OP_XOR = 3'b110,
      OP_NOT = 3'b111
   } op_e;

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e state_q, state_d;
   op_e    op;

   logic [WIDTH:0]     add_s, sub_d;
   logic [WIDTH-1:0]   lo_w;
   logic [2*WIDTH-1:0] s_res;
   logic               s_c, s_v, s_dz;
   logic               multi_go, last;

   logic               mul_q;
   logic [WIDTH-1:0]   opnd_q, hi_q, lo_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH:0]     msum, trial;
   logic [WIDTH-1:0]   it_hi, it_lo;

   assign op       = op_e'(opcode);
   assign add_s    = {1'b0, a} + {1'b0, b};
   assign sub_d    = {1'b0, a} - {1'b0, b};
   assign multi_go = start && (op == OP_MUL || (op == OP_DIV && b != '0));
   assign last     = (state_q == S_RUN) && (cnt_q == CW'(WIDTH - 1));
   assign busy     = (state_q == S_RUN);

   always_comb begin
      lo_w = '0;
      s_c  = 1'b0;
      s_v  = 1'b0;
      s_dz = 1'b0;
      unique case (op)
         OP_ADD: begin
            lo_w = add_s[WIDTH-1:0];
            s_c  = add_s[WIDTH];
            s_v  = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            lo_w = sub_d[WIDTH-1:0];
            s_c  = ~sub_d[WIDTH];
            s_v  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_d[WIDTH-1] != a[WIDTH-1]);
         end
         OP_MUL: lo_w = '0;
         OP_DIV: s_dz = (b == '0);
         OP_AND: lo_w = a & b;
         OP_OR:  lo_w = a | b;
         OP_XOR: lo_w = a ^ b;
         OP_NOT: lo_w = ~a;
      endcase
`ifdef SEQ_ALU_SAT_EN
      // clamp direction follows the sign of a on overflow
      if (s_v)
         lo_w = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
`endif
      s_res = {{WIDTH{1'b0}}, lo_w};
   end

   // one MUL or DIV step; hi/lo hold product or {rem, dividend/quotient}
   always_comb begin
      msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
      if (mul_q) begin
         {it_hi, it_lo} = {msum, lo_q[WIDTH-1:1]};
      end else if (!trial[WIDTH]) begin
         it_hi = trial[WIDTH-1:0];
         it_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
         it_hi = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
         it_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (multi_go) state_d = S_RUN;
         S_RUN:  if (last) state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done      <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         div_zero  <= 1'b0;
         mul_q     <= 1'b0;
         opnd_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         cnt_q     <= '0;
      end else begin
         done <= 1'b0;
         if (state_q == S_IDLE && start) begin
            if (multi_go) begin
               mul_q  <= (op == OP_MUL);
               opnd_q <= b;
               hi_q   <= '0;
               lo_q   <= a;
               cnt_q  <= '0;
            end else begin
               done      <= 1'b1;
               result    <= s_res;
               carry_out <= s_c;
               overflow  <= s_v;
               zero      <= (s_res == '0);
               div_zero  <= s_dz;
            end
         end else if (state_q == S_RUN) begin
            hi_q  <= it_hi;
            lo_q  <= it_lo;
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
               done      <= 1'b1;
               result    <= {it_hi, it_lo};
               carry_out <= 1'b0;
               overflow  <= mul_q && (it_hi != '0);
               zero      <= ({it_hi, it_lo} == '0);
               div_zero  <= 1'b0;
            end
         end
      end
   end

endmodule
